// File: rtl/spi_slave_regif.sv
// SPI-slave (mode 3) register-access front end: oversampled pins, frame parser with CRC16-CCITT,
// single-cycle register strobes and read data returned later in the same frame.
module spi_slave_regif #(
    parameter int         DATA_W     = 32,
    parameter int         ADDR_W     = 6,
    parameter int         CRC_EN     = 1,
    parameter int         TURN_BYTES = 2,
    parameter logic [7:0] CMD_REG    = 8'h02
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ssclk,
    input  logic              scsn,
    input  logic              smosi,
    output logic              smiso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_ok,
    output logic              crc_err,
    output logic [7:0]        err_cnt
);
    localparam int DB = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_CRC, S_TURN, S_RDATA, S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
    logic              sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic [6:0]        rx_sr_q, rx_sr_d;
    logic [15:0]       crc_q, crc_d;
    logic [7:0]        crc_h_q, crc_h_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d, reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] wdata_shadow_q, wdata_shadow_d, reg_wdata_q, reg_wdata_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic              smiso_q, smiso_d;
    logic              reg_we_q, reg_we_d, reg_re_q, reg_re_d;
    logic              frame_ok_q, frame_ok_d, crc_err_q, crc_err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic              sclk_rise, sclk_fall, cs_fall, cs_high, crc_match;
    logic [7:0]        rx_byte;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // cs synchroniser starts low so a held-low scsn after reset never looks like a new frame
            sclk_sync_q    <= 2'b11;
            sclk_prev_q    <= 1'b1;
            cs_sync_q      <= 2'b00;
            cs_prev_q      <= 1'b0;
            mosi_sync_q    <= 2'b00;
            state_q        <= S_IDLE;
            bit_cnt_q      <= '0;
            byte_cnt_q     <= '0;
            rx_sr_q        <= '0;
            crc_q          <= 16'hFFFF;
            crc_h_q        <= '0;
            is_wr_q        <= 1'b0;
            addr_q         <= '0;
            wdata_shadow_q <= '0;
            tx_sr_q        <= '0;
            smiso_q        <= 1'b0;
            reg_addr_q     <= '0;
            reg_wdata_q    <= '0;
            reg_we_q       <= 1'b0;
            reg_re_q       <= 1'b0;
            frame_ok_q     <= 1'b0;
            crc_err_q      <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            sclk_sync_q    <= sclk_sync_d;
            sclk_prev_q    <= sclk_prev_d;
            cs_sync_q      <= cs_sync_d;
            cs_prev_q      <= cs_prev_d;
            mosi_sync_q    <= mosi_sync_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            rx_sr_q        <= rx_sr_d;
            crc_q          <= crc_d;
            crc_h_q        <= crc_h_d;
            is_wr_q        <= is_wr_d;
            addr_q         <= addr_d;
            wdata_shadow_q <= wdata_shadow_d;
            tx_sr_q        <= tx_sr_d;
            smiso_q        <= smiso_d;
            reg_addr_q     <= reg_addr_d;
            reg_wdata_q    <= reg_wdata_d;
            reg_we_q       <= reg_we_d;
            reg_re_q       <= reg_re_d;
            frame_ok_q     <= frame_ok_d;
            crc_err_q      <= crc_err_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    always_comb begin
        sclk_sync_d    = {sclk_sync_q[0], ssclk};
        sclk_prev_d    = sclk_sync_q[1];
        cs_sync_d      = {cs_sync_q[0], scsn};
        cs_prev_d      = cs_sync_q[1];
        mosi_sync_d    = {mosi_sync_q[0], smosi};
        sclk_rise      = sclk_sync_q[1] & ~sclk_prev_q;
        sclk_fall      = ~sclk_sync_q[1] & sclk_prev_q;
        cs_fall        = ~cs_sync_q[1] & cs_prev_q;
        cs_high        = cs_sync_q[1];
        rx_byte        = {rx_sr_q, mosi_sync_q[1]};
        crc_match      = (CRC_EN == 0) || ({crc_h_q, rx_byte} == crc_q);
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        rx_sr_d        = rx_sr_q;
        crc_d          = crc_q;
        crc_h_d        = crc_h_q;
        is_wr_d        = is_wr_q;
        addr_d         = addr_q;
        wdata_shadow_d = wdata_shadow_q;
        tx_sr_d        = tx_sr_q;
        smiso_d        = smiso_q;
        reg_addr_d     = reg_addr_q;
        reg_wdata_d    = reg_wdata_q;
        reg_we_d       = 1'b0;
        reg_re_d       = 1'b0;
        frame_ok_d     = 1'b0;
        crc_err_d      = 1'b0;
        err_cnt_d      = err_cnt_q;

        if (reg_re_q) tx_sr_d = reg_rdata;

        if (cs_high) begin
            state_d    = S_IDLE;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end else if (state_q == S_IDLE) begin
            if (cs_fall) begin
                state_d    = S_CMD;
                bit_cnt_d  = '0;
                byte_cnt_d = '0;
                rx_sr_d    = '0;
                crc_d      = 16'hFFFF;
                tx_sr_d    = '0;
            end
        end else if (sclk_rise) begin
            rx_sr_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_cnt_d = byte_cnt_q + 8'd1;
                case (state_q)
                    S_CMD: begin
                        if (rx_byte == CMD_REG) begin
                            crc_d   = crc16_byte(crc_q, rx_byte);
                            state_d = S_ADDR;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                    S_ADDR: begin
                        is_wr_d    = rx_byte[7];
                        addr_d     = rx_byte[ADDR_W-1:0];
                        crc_d      = crc16_byte(crc_q, rx_byte);
                        state_d    = S_DATA;
                        byte_cnt_d = '0;
                    end
                    S_DATA: begin
                        wdata_shadow_d = DATA_W'({wdata_shadow_q, rx_byte});
                        crc_d          = crc16_byte(crc_q, rx_byte);
                        if (byte_cnt_q == 8'(DB - 1)) begin
                            state_d    = S_CRC;
                            byte_cnt_d = '0;
                        end
                    end
                    S_CRC: begin
                        if (byte_cnt_q == 8'd0) begin
                            crc_h_d = rx_byte;
                        end else begin
                            // Write and rejected frames return zeros; reads reload from reg_rdata later
                            tx_sr_d    = '0;
                            state_d    = S_TURN;
                            byte_cnt_d = '0;
                            if (crc_match) begin
                                frame_ok_d = 1'b1;
                                reg_addr_d = addr_q;
                                if (is_wr_q) begin
                                    reg_we_d    = 1'b1;
                                    reg_wdata_d = wdata_shadow_q;
                                end else begin
                                    reg_re_d = 1'b1;
                                end
                            end else begin
                                crc_err_d = 1'b1;
                                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                            end
                        end
                    end
                    S_TURN: begin
                        if (byte_cnt_q == 8'(TURN_BYTES - 1)) begin
                            state_d    = S_RDATA;
                            byte_cnt_d = '0;
                        end
                    end
                    S_RDATA: begin
                        if (byte_cnt_q == 8'(DB - 1)) state_d = S_DRAIN;
                    end
                    default: ;
                endcase
            end
        end

        if (cs_high || state_q != S_RDATA) begin
            smiso_d = 1'b0;
        end else if (sclk_fall) begin
            smiso_d = tx_sr_q[DATA_W-1];
            tx_sr_d = tx_sr_q << 1;
        end
    end

    assign smiso     = smiso_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign frame_ok  = frame_ok_q;
    assign crc_err   = crc_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Bench for spi_slave_regif: three instances (default, CRC disabled 16-bit, 8-bit for counter
// saturation) sharing SPI pins, with a scoreboard of expected strobes and smiso bytes.
module tb_spi_slave_regif;
  localparam int CLK_HALF = 5;
  localparam int SPI_HALF = 40;

  logic clk = 1'b0;
  logic reset;
  logic ssclk, scsn, smosi;
  int   sel;
  logic scsn_a, scsn_b, scsn_c, smiso_a, smiso_b, smiso_c, smiso_s;

  logic [5:0]  reg_addr_a, reg_addr_b, reg_addr_c;
  logic [31:0] reg_wdata_a, reg_rdata_a;
  logic [15:0] reg_wdata_b, reg_rdata_b;
  logic [7:0]  reg_wdata_c, reg_rdata_c;
  logic        reg_we_a, reg_re_a, frame_ok_a, crc_err_a;
  logic        reg_we_b, reg_re_b, frame_ok_b, crc_err_b;
  logic        reg_we_c, reg_re_c, frame_ok_c, crc_err_c;
  logic [7:0]  err_cnt_a, err_cnt_b, err_cnt_c;

  assign scsn_a  = (sel == 0) ? scsn : 1'b1;
  assign scsn_b  = (sel == 1) ? scsn : 1'b1;
  assign scsn_c  = (sel == 2) ? scsn : 1'b1;
  assign smiso_s = (sel == 0) ? smiso_a : (sel == 1) ? smiso_b : smiso_c;
  assign reg_rdata_a = 32'hDEADBEEF;
  assign reg_rdata_b = 16'h1234;
  assign reg_rdata_c = 8'h00;

  spi_slave_regif u_dut_a (
    .clk(clk), .reset(reset), .ssclk(ssclk), .scsn(scsn_a), .smosi(smosi), .smiso(smiso_a),
    .reg_addr(reg_addr_a), .reg_wdata(reg_wdata_a), .reg_we(reg_we_a), .reg_re(reg_re_a),
    .reg_rdata(reg_rdata_a), .frame_ok(frame_ok_a), .crc_err(crc_err_a), .err_cnt(err_cnt_a)
  );

  spi_slave_regif #(.DATA_W(16), .CRC_EN(0)) u_dut_b (
    .clk(clk), .reset(reset), .ssclk(ssclk), .scsn(scsn_b), .smosi(smosi), .smiso(smiso_b),
    .reg_addr(reg_addr_b), .reg_wdata(reg_wdata_b), .reg_we(reg_we_b), .reg_re(reg_re_b),
    .reg_rdata(reg_rdata_b), .frame_ok(frame_ok_b), .crc_err(crc_err_b), .err_cnt(err_cnt_b)
  );

  spi_slave_regif #(.DATA_W(8), .TURN_BYTES(1)) u_dut_c (
    .clk(clk), .reset(reset), .ssclk(ssclk), .scsn(scsn_c), .smosi(smosi), .smiso(smiso_c),
    .reg_addr(reg_addr_c), .reg_wdata(reg_wdata_c), .reg_we(reg_we_c), .reg_re(reg_re_c),
    .reg_rdata(reg_rdata_c), .frame_ok(frame_ok_c), .crc_err(crc_err_c), .err_cnt(err_cnt_c)
  );

  // clock / reset
  always #CLK_HALF clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  logic [37:0] exp_we_q[$];
  logic [5:0]  exp_re_q[$];
  int          ok_pulses, err_pulses;
  bit          frame_done;

  function automatic logic [15:0] crc_bytes(input int n);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      b = tx_q[k];
      for (int i = 7; i >= 0; i--) begin
        fb = c[15] ^ b[i];
        c  = c << 1;
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic build(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] data,
                       input int db, input bit bad_crc, input int tail);
    logic [15:0] c;
    tx_q.delete();
    tx_q.push_back(cmd);
    tx_q.push_back(addr);
    for (int i = db - 1; i >= 0; i--) tx_q.push_back(data[i*8 +: 8]);
    c = bad_crc ? 16'h0A0B : crc_bytes(tx_q.size());
    tx_q.push_back(c[15:8]);
    tx_q.push_back(c[7:0]);
    for (int i = 0; i < tail; i++) tx_q.push_back(8'h00);
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(8'h00);
  endtask

  // driver: mode 3, smiso sampled just before each rising edge
  task automatic drive_bytes(input int nbytes, input bit toggle_cs);
    logic [7:0] b, r, e;
    if (toggle_cs) scsn = 1'b0;
    #20;
    for (int k = 0; k < nbytes; k++) begin
      b = tx_q[k];
      r = 8'h00;
      for (int i = 7; i >= 0; i--) begin
        ssclk = 1'b0;
        smosi = b[i];
        #SPI_HALF;
        r = {r[6:0], smiso_s};
        ssclk = 1'b1;
        #SPI_HALF;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL miso_byte[%0d] got=%h expected=<none queued>", k, r);
      end else begin
        e = exp_q.pop_front();
        if (r !== e) begin
          errors++;
          $display("FAIL miso_byte[%0d] got=%h expected=%h", k, r, e);
        end
      end
    end
    #SPI_HALF;
    scsn = 1'b1;
    #30;
  endtask

  // scoreboard side: pops expected strobes as the selected DUT issues them
  task automatic watch();
    logic        we, re, ok, ce;
    logic [37:0] got_w, e_w;
    logic [5:0]  got_a, e_a;
    while (!frame_done) begin
      @(negedge clk);
      case (sel)
        0: begin we = reg_we_a; re = reg_re_a; ok = frame_ok_a; ce = crc_err_a;
                 got_w = {reg_addr_a, reg_wdata_a}; got_a = reg_addr_a; end
        1: begin we = reg_we_b; re = reg_re_b; ok = frame_ok_b; ce = crc_err_b;
                 got_w = {reg_addr_b, 16'h0, reg_wdata_b}; got_a = reg_addr_b; end
        default: begin we = reg_we_c; re = reg_re_c; ok = frame_ok_c; ce = crc_err_c;
                 got_w = {reg_addr_c, 24'h0, reg_wdata_c}; got_a = reg_addr_c; end
      endcase
      if (we) begin
        checks++;
        if (exp_we_q.size() == 0) begin
          errors++;
          $display("FAIL reg_we_unexpected got=%h expected=<no write>", got_w);
        end else begin
          e_w = exp_we_q.pop_front();
          if (got_w !== e_w) begin
            errors++;
            $display("FAIL reg_we_payload got=%h expected=%h", got_w, e_w);
          end
        end
      end
      if (re) begin
        checks++;
        if (exp_re_q.size() == 0) begin
          errors++;
          $display("FAIL reg_re_unexpected addr=%h expected=<no read>", got_a);
        end else begin
          e_a = exp_re_q.pop_front();
          if (got_a !== e_a) begin
            errors++;
            $display("FAIL reg_re_addr got=%h expected=%h", got_a, e_a);
          end
        end
      end
      if (ok) ok_pulses++;
      if (ce) err_pulses++;
    end
  endtask

  task automatic send_frame(input int nbytes, input bit toggle_cs);
    frame_done = 1'b0;
    ok_pulses  = 0;
    err_pulses = 0;
    fork
      begin
        drive_bytes(nbytes, toggle_cs);
        frame_done = 1'b1;
      end
      watch();
    join
  endtask

  task automatic check_frame(input string name, input int exp_ok, input int exp_err);
    checks++;
    if (ok_pulses != exp_ok || err_pulses != exp_err) begin
      errors++;
      $display("FAIL %s_pulses frame_ok=%0d crc_err=%0d expected %0d/%0d",
               name, ok_pulses, err_pulses, exp_ok, exp_err);
    end
    checks++;
    if (exp_we_q.size() != 0 || exp_re_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing pending we=%0d re=%0d miso=%0d expected 0/0/0",
               name, exp_we_q.size(), exp_re_q.size(), exp_q.size());
      exp_we_q.delete(); exp_re_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ssclk = 1'b1; scsn = 1'b1; smosi = 1'b0; sel = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({smiso_a, reg_addr_a, reg_wdata_a, reg_we_a, reg_re_a, frame_ok_a, crc_err_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_a got=%h expected=0",
               {smiso_a, reg_addr_a, reg_wdata_a, reg_we_a, reg_re_a, frame_ok_a, crc_err_a});
    end
    checks++;
    if (err_cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL reset_err_cnt_a got=%0d expected=0", err_cnt_a);
    end
    checks++;
    if ({smiso_b, reg_we_b, reg_re_b, frame_ok_b, crc_err_b, err_cnt_b,
         smiso_c, reg_we_c, reg_re_c, frame_ok_c, crc_err_c, err_cnt_c} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_bc got nonzero expected=0");
    end
    reset = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_write();
    sel = 0;
    build(8'h02, 8'h85, 32'h0000_0202, 4, 1'b0, 7);
    exp_we_q.push_back({6'd5, 32'h0000_0202});
    push_zeros(15);
    send_frame(15, 1'b1);
    check_frame("write", 1, 0);
  endtask

  task automatic test_crc_error();
    sel = 0;
    build(8'h02, 8'h85, 32'h0000_0202, 4, 1'b1, 7);
    push_zeros(15);
    send_frame(15, 1'b1);
    check_frame("crc_err", 0, 1);
    checks++;
    if (err_cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL crc_err_cnt got=%0d expected=1", err_cnt_a);
    end
  endtask

  task automatic test_read();
    sel = 0;
    build(8'h02, 8'h01, 32'h0, 4, 1'b0, 7);
    exp_re_q.push_back(6'd1);
    push_zeros(10);
    exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    push_zeros(1);
    send_frame(15, 1'b1);
    check_frame("read", 1, 0);
  endtask

  task automatic test_bad_cmd();
    sel = 0;
    build(8'h01, 8'h85, 32'h0000_0202, 4, 1'b0, 7);
    push_zeros(15);
    send_frame(15, 1'b1);
    check_frame("bad_cmd", 0, 0);
  endtask

  task automatic test_back_to_back();
    sel = 0;
    build(8'h02, 8'h85, 32'h0000_0202, 4, 1'b0, 7);
    push_zeros(3);
    send_frame(3, 1'b1);
    check_frame("partial", 0, 0);
    build(8'h02, 8'h87, 32'h1357_9BDF, 4, 1'b0, 7);
    exp_we_q.push_back({6'd7, 32'h1357_9BDF});
    push_zeros(15);
    send_frame(15, 1'b1);
    check_frame("after_partial", 1, 0);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    sel = 0;
    build(8'h02, 8'h85, 32'h0000_0202, 4, 1'b0, 7);
    scsn = 1'b0;
    #20;
    for (int k = 0; k < 3; k++) begin
      b = tx_q[k];
      for (int i = 7; i >= 0; i--) begin
        ssclk = 1'b0; smosi = b[i]; #SPI_HALF;
        ssclk = 1'b1; #SPI_HALF;
      end
    end
    ssclk = 1'b0; #SPI_HALF; ssclk = 1'b1; #SPI_HALF;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({smiso_a, reg_addr_a, reg_wdata_a, reg_we_a, reg_re_a, frame_ok_a, crc_err_a, err_cnt_a} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%h expected=0",
               {smiso_a, reg_addr_a, reg_wdata_a, reg_we_a, reg_re_a, frame_ok_a, crc_err_a, err_cnt_a});
    end
    #50;
    reset = 1'b0;
    #50;
    // scsn still low: a complete frame without a fresh falling edge must be ignored
    push_zeros(15);
    send_frame(15, 1'b0);
    check_frame("no_new_cs", 0, 0);
  endtask

  task automatic test_crc_disabled();
    sel = 1;
    build(8'h02, 8'hBF, 32'h0000_A55A, 2, 1'b1, 4);
    exp_we_q.push_back({6'h3F, 16'h0, 16'hA55A});
    push_zeros(10);
    send_frame(10, 1'b1);
    check_frame("crc_off", 1, 0);
    checks++;
    if (err_cnt_b !== 8'd0) begin
      errors++;
      $display("FAIL crc_off_err_cnt got=%0d expected=0", err_cnt_b);
    end
  endtask

  task automatic test_err_saturate();
    int total;
    total = 0;
    sel = 2;
    for (int n = 0; n < 256; n++) begin
      build(8'h02, 8'h85, {24'h0, 8'($urandom_range(0, 255))}, 1, 1'b1, 0);
      push_zeros(5);
      send_frame(5, 1'b1);
      total += err_pulses;
      if (n == 254) begin
        checks++;
        if (err_cnt_c !== 8'd255) begin
          errors++;
          $display("FAIL sat_reach got=%0d expected=255", err_cnt_c);
        end
      end
    end
    checks++;
    if (err_cnt_c !== 8'd255) begin
      errors++;
      $display("FAIL sat_hold got=%0d expected=255", err_cnt_c);
    end
    checks++;
    if (total != 256) begin
      errors++;
      $display("FAIL sat_pulses got=%0d expected=256", total);
    end
    check_frame("sat_last", 0, 1);
  endtask

  initial begin
    test_reset();
    test_write();
    test_crc_error();
    test_read();
    test_bad_cmd();
    test_back_to_back();
    test_reset_mid_frame();
    test_crc_disabled();
    test_err_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
